// File: rtl/onehot_dec_pkg.sv
// Shared widths, FSM state encodings and the one-hot decode helper for onehot_decoder_seq.
// Declarations only: no logic, no latency, no flow control.
package onehot_dec_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int OUT_W     = 2**IN_W_DEF;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF) + 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  function automatic logic [OUT_W-1:0] decode(input logic [IN_W_DEF-1:0] code);
    return OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Circular-buffer FIFO with wrap-bit pointers; head is readable combinationally (zero latency).
// full/empty/level come from registered pointers; caller never pushes when full or pops when empty.
module sync_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [W-1:0]            din_i,
  input  logic                    pop_i,
  output logic [W-1:0]            dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Buffers binary codes and plays each back as a one-hot word held HOLD_CYCLES cycles; first word 1 cycle after accept.
// code_ready_o drops while the FIFO is full; ONEHOT_DECODER_GAP_EN inserts one idle cycle between words.
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         code_i,
  input  logic                    code_valid_i,
  output logic                    code_ready_o,
  output logic [2**IN_W-1:0]      q_o,
  output logic                    q_valid_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int Q_W   = 2**IN_W;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LVL_W = (DEPTH == DEPTH_DEF) ? PTR_W : $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic             q_vld_q, q_vld_d;

  logic             push, load;
  logic             fifo_full, fifo_empty;
  logic [IN_W-1:0]  head;
  logic [LVL_W-1:0] fifo_lvl;
  logic [Q_W-1:0]   dec_word;

  assign push = code_valid_i & ~fifo_full;

  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .W     (IN_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (code_i),
    .pop_i   (load),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  // The shared helper is sized for the default code width; other widths shift directly.
  if (IN_W == IN_W_DEF) begin : g_pkg_dec
    assign dec_word = decode(head);
  end else begin : g_gen_dec
    assign dec_word = Q_W'(1) << head;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    q_vld_d = q_vld_q;
    load    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`ifdef ONEHOT_DECODER_GAP_EN
        else begin
          state_d = ST_GAP;
          q_d     = '0;
          q_vld_d = 1'b0;
        end
`else
        else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          q_d     = '0;
          q_vld_d = 1'b0;
        end
`endif
      end
      // IDLE and GAP both take the fetch decision; unused encodings recover here too.
      default: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          q_d     = '0;
          q_vld_d = 1'b0;
        end
      end
    endcase
    if (load) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_LD;
      q_d     = dec_word;
      q_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
    end
  end

  assign code_ready_o = ~fifo_full;
  assign q_o          = q_q;
  assign q_valid_o    = q_vld_q;
  assign busy_o       = ~fifo_empty | (state_q != ST_IDLE);
  assign level_o      = fifo_lvl;

  a_onehot_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    q_valid_o |-> $onehot(q_o));
  a_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !q_valid_o |-> (q_o == '0));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    load |-> !fifo_empty);
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    32'(level_o) <= DEPTH);

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq (DEPTH=4, HOLD_CYCLES=4); follows ONEHOT_DECODER_GAP_EN if defined.
module tb_onehot_decoder_seq;

  localparam int HOLD = 4;
`ifdef ONEHOT_DECODER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] code_i;
  logic       code_valid_i;
  logic       code_ready_o;
  logic [7:0] q_o;
  logic       q_valid_o;
  logic       busy_o;
  logic [2:0] level_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic       cap_en = 1'b0;
  logic [7:0] trace[$];
  logic [7:0] ev[$];
  int         el[$];
  int         lvl_max;

  always #5 clk = ~clk;

  onehot_decoder_seq #(
    .IN_W        (3),
    .DEPTH       (4),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .q_o          (q_o),
    .q_valid_o    (q_valid_o),
    .busy_o       (busy_o),
    .level_o      (level_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cap_en) begin
      trace.push_back(q_o);
      if (int'(level_o) > lvl_max) lvl_max = int'(level_o);
      if (q_valid_o) chk("onehot", 32'($countones(q_o)), 32'd1);
      else           chk("idle_zero", 32'(q_o), 32'd0);
    end
  end

  // Called on a falling edge; returns on the falling edge right after the accepting rising edge.
  task automatic send(input logic [2:0] c);
    int t;
    t = 0;
    code_i       = c;
    code_valid_i = 1'b1;
    while (!code_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_stall_bound", 32'(t < 200), 32'd1);
    @(negedge clk);
    code_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle_bound"}, 32'(t < 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic start_cap();
    @(posedge clk);
    #1;
    trace.delete();
    lvl_max = 0;
    cap_en  = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_cap();
    #1;
    cap_en = 1'b0;
  endtask

  task automatic add_word(input logic [2:0] c);
    logic [7:0] one;
    one = 8'h01;
    if (GAP != 0 && ev.size() != 0) begin
      ev.push_back(8'h00);
      el.push_back(1);
    end
    ev.push_back(one << c);
    el.push_back(HOLD);
  endtask

  // Collapses the captured trace into (value, run length) pairs between the first and last non-zero cycle.
  task automatic check_runs(input string tag, output int lead);
    logic [7:0] rv[$];
    int         rl[$];
    int         first;
    int         last;
    first = -1;
    last  = -1;
    foreach (trace[i]) begin
      if (trace[i] != 8'h00) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    lead = first;
    if (first >= 0) begin
      for (int i = first; i <= last; i++) begin
        if (rv.size() == 0 || rv[rv.size()-1] != trace[i]) begin
          rv.push_back(trace[i]);
          rl.push_back(1);
        end else begin
          rl[rl.size()-1] = rl[rl.size()-1] + 1;
        end
      end
    end
    chk({tag, "_nruns"}, 32'(rv.size()), 32'(ev.size()));
    for (int i = 0; i < ev.size() && i < rv.size(); i++) begin
      chk($sformatf("%s_val%0d", tag, i), 32'(rv[i]), 32'(ev[i]));
      chk($sformatf("%s_len%0d", tag, i), 32'(rl[i]), 32'(el[i]));
    end
    ev.delete();
    el.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lead;
    int nz;
    rst_n        = 1'b0;
    code_i       = 3'd0;
    code_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q",     32'(q_o),          32'h00);
    chk("rst_qv",    32'(q_valid_o),    32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_level", 32'(level_o),      32'd0);
    chk("rst_ready", 32'(code_ready_o), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single code 5: one cycle of latency, held four cycles.
    start_cap();
    send(3'd5);
    chk("single_lvl_e0", 32'(level_o),   32'd1);
    chk("single_qv_e0",  32'(q_valid_o), 32'd0);
    @(negedge clk);
    chk("single_q_e1",   32'(q_o),       32'h20);
    chk("single_lvl_e1", 32'(level_o),   32'd0);
    wait_idle("single");
    stop_cap();
    add_word(3'd5);
    check_runs("single", lead);
    chk("single_lead", 32'(lead), 32'd2);
    chk("single_busy_end", 32'(busy_o), 32'd0);
    chk("single_q_end",    32'(q_o),    32'h00);

    // Back-to-back 0,7,2; the second push coincides with the first pop.
    start_cap();
    send(3'd0);
    chk("b2b_lvl0", 32'(level_o), 32'd1);
    send(3'd7);
    chk("b2b_lvl1", 32'(level_o), 32'd1);
    send(3'd2);
    chk("b2b_lvl2", 32'(level_o), 32'd2);
    wait_idle("b2b");
    stop_cap();
    add_word(3'd0);
    add_word(3'd7);
    add_word(3'd2);
    check_runs("b2b", lead);

    // Valid held with codes 1..7,0: FIFO fills and refills at the full boundary.
    start_cap();
    for (int c = 1; c <= 5; c++) send(3'(c));
    chk("full_lvl",   32'(level_o),      32'd4);
    chk("full_ready", 32'(code_ready_o), 32'd0);
    send(3'd6);
    chk("full_refill_lvl", 32'(level_o), 32'd4);
    send(3'd7);
    send(3'd0);
    wait_idle("full");
    stop_cap();
    chk("full_lvl_max", 32'(lvl_max), 32'd4);
    for (int c = 1; c <= 7; c++) add_word(3'(c));
    add_word(3'd0);
    check_runs("full", lead);

    // Every code twice: exhaustive decode with pointer wrap.
    start_cap();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        send(3'(c));
        add_word(3'(c));
      end
    end
    wait_idle("exh");
    stop_cap();
    check_runs("exh", lead);

    // Reset two cycles into a hold with another code still queued.
    send(3'd3);
    send(3'd6);
    @(negedge clk);
    chk("mid_q_before", 32'(q_o), 32'h08);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",     32'(q_o),       32'h00);
    chk("mid_rst_qv",    32'(q_valid_o), 32'd0);
    chk("mid_rst_level", 32'(level_o),   32'd0);
    chk("mid_rst_busy",  32'(busy_o),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(code_ready_o), 32'd1);
    start_cap();
    repeat (20) @(negedge clk);
    stop_cap();
    nz = 0;
    foreach (trace[i]) if (trace[i] != 8'h00) nz++;
    chk("mid_silent", 32'(nz), 32'd0);
    chk("mid_busy_after", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
